// File: rtl/pipe_pkg.sv
// Shared definitions for the arithmetic pipe and its checker: default sizes
// and the single reference formula for the pipe result.
package pipe_pkg;

    localparam int N_DEF       = 10;
    localparam int LATENCY_DEF = 3;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        CHK_IDLE = 2'd0,
        CHK_PASS = 2'd1,
        CHK_FAIL = 2'd2
    } chk_result_e;

    // ((a+b)*(c-d)) mod 2^n; every intermediate also wraps mod 2^n.
    // Operands are passed zero-extended to 64 bits; n must not exceed 64.
    function automatic logic [63:0] pipe_expected(input logic [63:0] a,
                                                  input logic [63:0] b,
                                                  input logic [63:0] c,
                                                  input logic [63:0] d,
                                                  input int unsigned n);
        logic [63:0] mask;
        logic [63:0] sum;
        logic [63:0] diff;
        logic [63:0] prod;
        mask = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
        sum  = (a + b) & mask;
        diff = (c - d) & mask;
        prod = (sum * diff) & mask;
        return prod;
    endfunction

endpackage

// File: rtl/pipe_checker_delay.sv
// Fixed-latency delay line; the MSB of each entry is its valid bit, which is
// the only part cleared by reset (the payload is don't-care when invalid).
module pipe_delay
    import pipe_pkg::*;
#(
    parameter int WIDTH = N_DEF + 1,
    parameter int DEPTH = LATENCY_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] entry,
    output logic [WIDTH-1:0] head
);

    logic [DEPTH-1:0] vld_p;
    logic [WIDTH-2:0] data_p [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= entry[WIDTH-1];
            for (int i = 1; i < DEPTH; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        data_p[0] <= entry[WIDTH-2:0];
        for (int i = 1; i < DEPTH; i++) begin
            data_p[i] <= data_p[i-1];
        end
    end

    assign head = {vld_p[DEPTH-1], data_p[DEPTH-1]};

endmodule

// File: rtl/pipe_checker.sv
// Scoreboard for the (a+b)*(c-d) pipe: predicts each result, lines it up
// with f after LATENCY edges, and keeps saturating pass/error tallies.
module pipe_checker
    import pipe_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int LATENCY = LATENCY_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [N-1:0]     c,
    input  logic [N-1:0]     d,
    input  logic [N-1:0]     f,
    input  logic             clear,
    output logic             chk_valid,
    output logic             mismatch,
    output logic [N-1:0]     exp_f,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sticky
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [N-1:0] exp_p0;
    logic [N:0]   entry_p0;
    logic [N:0]   head_pl;
    logic         head_vld;
    logic [N-1:0] head_exp;
    chk_result_e  result;

    // Stage p0: prediction from the operands presented this cycle
    assign exp_p0   = N'(pipe_expected(64'(a), 64'(b), 64'(c), 64'(d), N));
    assign entry_p0 = {in_valid, exp_p0};

    pipe_delay #(
        .WIDTH (N + 1),
        .DEPTH (LATENCY)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .entry (entry_p0),
        .head  (head_pl)
    );

    // Stage pL: head of the delay line meets the pipe result
    assign head_vld = head_pl[N];
    assign head_exp = head_pl[N-1:0];

    always_comb begin
        result = CHK_IDLE;
        if (head_vld) begin
            result = (f == head_exp) ? CHK_PASS : CHK_FAIL;
        end
    end

    // Stage pL+1: registered verdict and tallies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_valid  <= 1'b0;
            mismatch   <= 1'b0;
            exp_f      <= '0;
            pass_count <= '0;
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else begin
            chk_valid <= head_vld;
            mismatch  <= (result == CHK_FAIL);
            if (head_vld) begin
                exp_f <= head_exp;
            end
            // A clear wins over a verdict on the same edge: reported, not counted.
            if (clear) begin
                pass_count <= '0;
                err_count  <= '0;
                err_sticky <= 1'b0;
            end else begin
                case (result)
                    CHK_PASS: pass_count <= sat_inc(pass_count);
                    CHK_FAIL: begin
                        err_count  <= sat_inc(err_count);
                        err_sticky <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_checker.sv
// Directed bench for pipe_checker with a behavioural 3-stage pipe feeding f.
module tb_pipe_checker;

    localparam int N   = 10;
    localparam int LAT = 3;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] a, b, c, d, f;
    logic         clear;
    logic         force_zero;

    logic         chk_valid, mismatch, err_sticky;
    logic [N-1:0] exp_f;
    logic [15:0]  pass_count, err_count;

    logic         s_chk_valid, s_mismatch, s_err_sticky;
    logic [N-1:0] s_exp_f;
    logic [1:0]   s_pass_count, s_err_count;

    int checks = 0;
    int errors = 0;

    pipe_checker #(.N(N), .LATENCY(LAT), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .d(d), .f(f), .clear(clear),
        .chk_valid(chk_valid), .mismatch(mismatch), .exp_f(exp_f),
        .pass_count(pass_count), .err_count(err_count), .err_sticky(err_sticky)
    );

    pipe_checker #(.N(N), .LATENCY(LAT), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .d(d), .f(f), .clear(clear),
        .chk_valid(s_chk_valid), .mismatch(s_mismatch), .exp_f(s_exp_f),
        .pass_count(s_pass_count), .err_count(s_err_count), .err_sticky(s_err_sticky)
    );

    // Behavioural pipe under test: result appears on f LAT edges after sampling
    logic [N-1:0] m_sum, m_diff, m_prod;
    logic [N-1:0] pipe_p [LAT];

    always_comb begin
        m_sum  = a + b;
        m_diff = c - d;
        m_prod = m_sum * m_diff;
    end

    always @(posedge clk) begin
        pipe_p[0] <= m_prod;
        for (int i = 1; i < LAT; i++) pipe_p[i] <= pipe_p[i-1];
    end

    assign f = force_zero ? '0 : pipe_p[LAT-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int va, input int vb, input int vc, input int vd);
        @(negedge clk);
        in_valid = 1'b1;
        a = N'(va); b = N'(vb); c = N'(vc); d = N'(vd);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; force_zero = 1'b0;
        a = '0; b = '0; c = '0; d = '0;

        #2;
        check("rst_chk_valid", chk_valid, 0);
        check("rst_mismatch", mismatch, 0);
        check("rst_exp_f", exp_f, 0);
        check("rst_pass", pass_count, 0);
        check("rst_err", err_count, 0);
        check("rst_sticky", err_sticky, 0);
        check("rst_sat_err", s_err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic single transaction
        drive(10, 12, 6, 2);
        idle(3);
        check("basic_early", chk_valid, 0);
        idle(1);
        check("basic_valid", chk_valid, 1);
        check("basic_exp", exp_f, 88);
        check("basic_mismatch", mismatch, 0);
        check("basic_pass", pass_count, 1);
        idle(1);
        check("basic_pulse_end", chk_valid, 0);
        check("basic_exp_hold", exp_f, 88);

        pulse_clear();
        check("clear_pass", pass_count, 0);

        // Streaming, back-to-back
        drive(10, 12, 6, 2);
        drive(10, 10, 5, 3);
        drive(20, 11, 1, 4);
        drive(12, 15, 4, 2);
        idle(1);
        check("stream0_valid", chk_valid, 1);
        check("stream0_exp", exp_f, 88);
        idle(1);
        check("stream1_valid", chk_valid, 1);
        check("stream1_exp", exp_f, 40);
        idle(1);
        check("stream2_valid", chk_valid, 1);
        check("stream2_exp", exp_f, 931);
        idle(1);
        check("stream3_valid", chk_valid, 1);
        check("stream3_exp", exp_f, 54);
        check("stream_pass", pass_count, 4);
        check("stream_err", err_count, 0);

        // Modular wrap of sum and difference
        drive(1023, 1023, 3, 1);
        drive(0, 1, 0, 1);
        idle(3);
        check("wrap0_exp", exp_f, 1020);
        check("wrap0_mismatch", mismatch, 0);
        idle(1);
        check("wrap1_exp", exp_f, 1023);
        check("wrap1_mismatch", mismatch, 0);
        check("wrap_pass", pass_count, 6);

        // Comparison on a clear edge is reported but not counted
        drive(10, 12, 6, 2);
        idle(2);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clredge_valid", chk_valid, 1);
        check("clredge_pass", pass_count, 0);

        // Forced fault, sticky across later passes, then clear
        force_zero = 1'b1;
        drive(10, 12, 6, 2);
        idle(4);
        check("fault_valid", chk_valid, 1);
        check("fault_mismatch", mismatch, 1);
        check("fault_exp", exp_f, 88);
        check("fault_err", err_count, 1);
        check("fault_sticky", err_sticky, 1);
        force_zero = 1'b0;
        drive(10, 10, 5, 3);
        idle(4);
        check("after_mismatch", mismatch, 0);
        check("after_pass", pass_count, 1);
        check("after_sticky", err_sticky, 1);
        pulse_clear();
        check("fclr_pass", pass_count, 0);
        check("fclr_err", err_count, 0);
        check("fclr_sticky", err_sticky, 0);

        // Saturation of a 2-bit error counter
        force_zero = 1'b1;
        repeat (5) drive(20, 11, 1, 4);
        idle(4);
        check("sat_main_err", err_count, 5);
        check("sat_small_err", s_err_count, 3);
        check("sat_small_sticky", s_err_sticky, 1);
        force_zero = 1'b0;

        // Reset with two sets in flight
        drive(10, 12, 6, 2);
        drive(10, 10, 5, 3);
        idle(1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_chk_valid", chk_valid, 0);
        check("arst_mismatch", mismatch, 0);
        check("arst_exp_f", exp_f, 0);
        check("arst_err", err_count, 0);
        check("arst_sticky", err_sticky, 0);
        check("arst_sat_err", s_err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("arst_no_ghost", chk_valid, 0);
        end

        drive(0, 1, 0, 1);
        idle(3);
        check("post_rst_early", chk_valid, 0);
        idle(1);
        check("post_rst_valid", chk_valid, 1);
        check("post_rst_exp", exp_f, 1023);
        check("post_rst_pass", pass_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
